// File: rtl/risac_fetch.sv
// risac_fetch: instruction prefetch unit.
// Issues sequential 32-bit fetches on a simple wait-stalled bus, buffers
// {instruction, pc} pairs in a DEPTH-entry FIFO and flushes on redirect.
// Bus requests are credit-limited so the FIFO can never overflow.
// Optional feature macro: RISAC_FETCH_FAULT_EN (misaligned redirect fault).
module risac_fetch #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                     clk,
   input  logic                     rst,
   output logic [31:0]              oIbusAddr,
   output logic                     oIbusRead,
   input  logic                     iIbusWait,
   input  logic [31:0]              iIbusData,
   output logic [31:0]              oInstr,
   output logic [31:0]              oInstrPc,
   output logic                     oInstrValid,
   input  logic                     iInstrReady,
   input  logic                     iRedirect,
   input  logic [31:0]              iRedirectPc,
   output logic [$clog2(DEPTH):0]   oLevel,
   output logic                     oFetchFault
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW+1:0] W_DEPTH = (AW+2)'(DEPTH);

   // fetch side state
   logic [31:0]   r_fpc;
   logic          r_hold;
   logic          r_resp_valid;
   logic          r_resp_discard;
   logic [31:0]   r_resp_pc;
   logic          r_stall_disc;
   logic          r_pend_valid;
   logic [31:0]   r_pend_pc;

   // FIFO state
   logic [31:0]   r_mem_instr [DEPTH];
   logic [31:0]   r_mem_pc    [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;

   logic [31:0]   w_tgt;
   logic          w_fault;
   logic [AW+1:0] w_occ;
   logic          w_credit;
   logic          w_accept;
   logic          w_stalled;
   logic          w_push;
   logic          w_pop;

`ifdef RISAC_FETCH_FAULT_EN
   logic          r_fault;
   logic [31:0]   r_fault_pc;
   logic          w_tgt_bad;

   assign w_tgt     = iRedirectPc;
   assign w_tgt_bad = (iRedirectPc[1:0] != 2'b00);
   assign w_fault   = r_fault;

   // Fault latch: every redirect re-evaluates alignment, reset clears it
   always_ff @(posedge clk) begin
      if (rst) begin
         r_fault    <= 1'b0;
         r_fault_pc <= RESET_PC;
      end else if (iRedirect) begin
         r_fault    <= w_tgt_bad;
         r_fault_pc <= iRedirectPc;
      end
   end
`else
   logic w_unused_lsbs;

   // Low address bits of a redirect are dropped so fetch stays word aligned
   assign w_tgt         = {iRedirectPc[31:2], 2'b00};
   assign w_fault       = 1'b0;
   assign w_unused_lsbs = ^iRedirectPc[1:0];
`endif

   // Outstanding work (buffered + one possible in-flight response) must stay below DEPTH
   assign w_occ     = {1'b0, r_count} + (AW+2)'(r_resp_valid);
   assign w_credit  = (w_occ < W_DEPTH);
   assign w_accept  = oIbusRead & ~iIbusWait;
   assign w_stalled = oIbusRead & iIbusWait;

   // A redirect flushes this cycle, so it also blocks any push or pop
   assign w_push = r_resp_valid & ~r_resp_discard & ~iRedirect;
   assign w_pop  = (r_count != '0) & iInstrReady & ~iRedirect;

   // Fetch PC, in-flight response tracking and redirects that land on a stalled request
   always_ff @(posedge clk) begin
      if (rst) begin
         r_fpc          <= RESET_PC;
         r_hold         <= 1'b0;
         r_resp_valid   <= 1'b0;
         r_resp_discard <= 1'b0;
         r_resp_pc      <= RESET_PC;
         r_stall_disc   <= 1'b0;
         r_pend_valid   <= 1'b0;
         r_pend_pc      <= RESET_PC;
      end else begin
         r_hold       <= w_stalled;
         r_resp_valid <= w_accept;
         if (w_accept) begin
            r_resp_pc      <= r_fpc;
            r_resp_discard <= iRedirect | r_stall_disc;
            r_stall_disc   <= 1'b0;
            r_pend_valid   <= 1'b0;
            if (iRedirect) begin
               r_fpc <= w_tgt;
            end else if (r_pend_valid) begin
               r_fpc <= r_pend_pc;
            end else begin
               r_fpc <= r_fpc + 32'd4;
            end
         end else begin
            r_resp_discard <= 1'b0;
            if (iRedirect) begin
               if (w_stalled) begin
                  // old address must stay on the bus; remember where to go next
                  r_stall_disc <= 1'b1;
                  r_pend_valid <= 1'b1;
                  r_pend_pc    <= w_tgt;
               end else begin
                  r_fpc <= w_tgt;
               end
            end
         end
      end
   end

   // FIFO pointers and occupancy; redirect empties the queue
   always_ff @(posedge clk) begin
      if (rst || iRedirect) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // FIFO storage, written on push only; contents need no reset
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_instr[r_wr_ptr] <= iIbusData;
         r_mem_pc[r_wr_ptr]    <= r_resp_pc;
      end
   end

   // Bus request and consumer-facing outputs
   always_comb begin
      oIbusRead   = 1'b0;
      oIbusAddr   = RESET_PC;
      oInstrValid = 1'b0;
      oLevel      = '0;
      oFetchFault = 1'b0;
      oInstr      = r_mem_instr[r_rd_ptr];
      oInstrPc    = r_mem_pc[r_rd_ptr];
      if (rst) begin
         oIbusRead   = 1'b0;
         oIbusAddr   = RESET_PC;
         oInstrValid = 1'b0;
         oLevel      = '0;
         oFetchFault = 1'b0;
      end else begin
         // a stalled request is held even if a fault has since been raised
         oIbusRead   = r_hold | (w_credit & ~w_fault);
         oIbusAddr   = r_fpc;
         oInstrValid = (r_count != '0);
         oLevel      = r_count;
         oFetchFault = w_fault;
`ifdef RISAC_FETCH_FAULT_EN
         if (r_fault) begin
            oInstrPc = r_fault_pc;
         end else begin
            oInstrPc = r_mem_pc[r_rd_ptr];
         end
`endif
      end
   end

endmodule

// File: tb/tb_risac_fetch.sv
// Self-checking bench for risac_fetch (DEPTH=4, RESET_PC=0).
// Bus model: memory word = address ^ mem_xor, returned one cycle after accept.
// Scoreboard: accepted, non-discarded fetches are queued and checked at pop.
module tb_risac_fetch;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] oIbusAddr;
   logic        oIbusRead;
   logic        iIbusWait = 1'b0;
   logic [31:0] iIbusData = 32'h0000_0000;
   logic [31:0] oInstr;
   logic [31:0] oInstrPc;
   logic        oInstrValid;
   logic        iInstrReady = 1'b0;
   logic        iRedirect = 1'b0;
   logic [31:0] iRedirectPc = 32'h0000_0000;
   logic [2:0]  oLevel;
   logic        oFetchFault;

   int          checks = 0;
   int          errors = 0;
   int          acc_cnt = 0;
   logic [63:0] exp_q [$];
   bit          disc_pend = 1'b0;
   logic [31:0] mem_xor = 32'h0000_0000;

   risac_fetch #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
      .clk         (clk),
      .rst         (rst),
      .oIbusAddr   (oIbusAddr),
      .oIbusRead   (oIbusRead),
      .iIbusWait   (iIbusWait),
      .iIbusData   (iIbusData),
      .oInstr      (oInstr),
      .oInstrPc    (oInstrPc),
      .oInstrValid (oInstrValid),
      .iInstrReady (iInstrReady),
      .iRedirect   (iRedirect),
      .iRedirectPc (iRedirectPc),
      .oLevel      (oLevel),
      .oFetchFault (oFetchFault)
   );

   always #5 clk = ~clk;

   // one clock cycle: sample before the edge, update scoreboard, drive bus data after
   task automatic tick();
      logic        acc;
      logic [31:0] a;
      logic [63:0] e;
      #2;
      acc = (oIbusRead === 1'b1) && (iIbusWait === 1'b0) && !rst;
      a   = oIbusAddr;
      if (!rst && !iRedirect && (oInstrValid === 1'b1) && iInstrReady) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_pop: got pc %h instr %h, expected no valid entry", oInstrPc, oInstr);
         end else begin
            e = exp_q.pop_front();
            if ({oInstr, oInstrPc} !== e) begin
               errors++;
               $display("FAIL sb_pop: got instr %h pc %h, expected instr %h pc %h",
                        oInstr, oInstrPc, e[63:32], e[31:0]);
            end
         end
      end
      if (rst) begin
         exp_q.delete();
         disc_pend = 1'b0;
      end else if (iRedirect) begin
         exp_q.delete();
         if ((oIbusRead === 1'b1) && iIbusWait) disc_pend = 1'b1;
      end
      if (acc) begin
         acc_cnt++;
         if (!iRedirect && !disc_pend) exp_q.push_back({a ^ mem_xor, a});
         disc_pend = 1'b0;
      end
      @(posedge clk);
      #1;
      iIbusData = acc ? (a ^ mem_xor) : 32'hDEAD_BEEF;
   endtask

   task automatic do_reset();
      rst         = 1'b1;
      iRedirect   = 1'b0;
      iRedirectPc = 32'h0000_0000;
      iIbusWait   = 1'b0;
      iInstrReady = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      #1;
      checks++;
      if (oIbusRead !== 1'b0 || oIbusAddr !== 32'h0 || oInstrValid !== 1'b0 ||
          oLevel !== 3'd0 || oFetchFault !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: got read %b addr %h valid %b level %0d fault %b, expected 0 0 0 0 0",
                  oIbusRead, oIbusAddr, oInstrValid, oLevel, oFetchFault);
      end
   endtask

   task automatic test_basic();
      mem_xor = 32'h0000_0000;
      do_reset();
      iInstrReady = 1'b1;
      #1;
      checks++;
      if (oIbusRead !== 1'b1 || oIbusAddr !== 32'h0) begin
         errors++;
         $display("FAIL basic_first_req: got read %b addr %h, expected 1 00000000", oIbusRead, oIbusAddr);
      end
      tick();
      checks++;
      if (oInstrValid !== 1'b0 || oIbusAddr !== 32'h4) begin
         errors++;
         $display("FAIL basic_n1: got valid %b addr %h, expected 0 00000004", oInstrValid, oIbusAddr);
      end
      tick();
      checks++;
      if (oInstrValid !== 1'b1 || oInstr !== 32'h0 || oInstrPc !== 32'h0) begin
         errors++;
         $display("FAIL basic_latency: got valid %b instr %h pc %h, expected 1 0 0", oInstrValid, oInstr, oInstrPc);
      end
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (oIbusAddr !== 32'(8 + 4 * i)) begin
            errors++;
            $display("FAIL basic_addr_seq: got %h expected %h", oIbusAddr, 32'(8 + 4 * i));
         end
         tick();
      end
   endtask

   task automatic test_full();
      mem_xor = 32'h5A5A_0000;
      do_reset();
      acc_cnt = 0;
      repeat (10) tick();
      checks++;
      if (acc_cnt != 4 || oLevel !== 3'd4 || oIbusRead !== 1'b0 || oInstrValid !== 1'b1) begin
         errors++;
         $display("FAIL full_stop: got accepts %0d level %0d read %b valid %b, expected 4 4 0 1",
                  acc_cnt, oLevel, oIbusRead, oInstrValid);
      end
      iInstrReady = 1'b1;
      tick();
      iInstrReady = 1'b0;
      repeat (6) tick();
      checks++;
      if (acc_cnt != 5 || oLevel !== 3'd4) begin
         errors++;
         $display("FAIL full_one_pop: got accepts %0d level %0d, expected 5 4", acc_cnt, oLevel);
      end
      iInstrReady = 1'b1;
      repeat (8) tick();
   endtask

   task automatic test_stall();
      mem_xor = 32'h1234_0000;
      do_reset();
      tick();
      tick();
      checks++;
      if (oIbusAddr !== 32'h8) begin
         errors++;
         $display("FAIL stall_setup: got addr %h expected 00000008", oIbusAddr);
      end
      iIbusWait = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (oIbusAddr !== 32'h8 || oIbusRead !== 1'b1) begin
            errors++;
            $display("FAIL stall_hold: got addr %h read %b, expected 00000008 1", oIbusAddr, oIbusRead);
         end
      end
      checks++;
      if (oLevel !== 3'd2) begin
         errors++;
         $display("FAIL stall_no_push: got level %0d expected 2", oLevel);
      end
      iIbusWait = 1'b0;
      tick();
      checks++;
      if (oIbusAddr !== 32'hC || oLevel !== 3'd2) begin
         errors++;
         $display("FAIL stall_accept: got addr %h level %0d, expected 0000000c 2", oIbusAddr, oLevel);
      end
      tick();
      checks++;
      if (oLevel !== 3'd3) begin
         errors++;
         $display("FAIL stall_push: got level %0d expected 3", oLevel);
      end
      iInstrReady = 1'b1;
      repeat (6) tick();
   endtask

   task automatic test_redirect_accept();
      mem_xor = 32'h0F0F_0000;
      do_reset();
      tick();
      tick();
      tick();
      checks++;
      if (oIbusAddr !== 32'hC || oIbusRead !== 1'b1) begin
         errors++;
         $display("FAIL redir_acc_setup: got addr %h read %b, expected 0000000c 1", oIbusAddr, oIbusRead);
      end
      iRedirect   = 1'b1;
      iRedirectPc = 32'h0000_0100;
      tick();
      iRedirect = 1'b0;
      checks++;
      if (oLevel !== 3'd0 || oInstrValid !== 1'b0 || oIbusAddr !== 32'h100) begin
         errors++;
         $display("FAIL redir_acc_flush: got level %0d valid %b addr %h, expected 0 0 00000100",
                  oLevel, oInstrValid, oIbusAddr);
      end
      tick();
      checks++;
      if (oLevel !== 3'd0) begin
         errors++;
         $display("FAIL redir_acc_discard: got level %0d expected 0", oLevel);
      end
      tick();
      checks++;
      if (oInstrValid !== 1'b1 || oInstrPc !== 32'h100 || oInstr !== (32'h100 ^ mem_xor)) begin
         errors++;
         $display("FAIL redir_acc_first: got valid %b pc %h instr %h, expected 1 00000100 %h",
                  oInstrValid, oInstrPc, oInstr, 32'h100 ^ mem_xor);
      end
   endtask

   task automatic test_redirect_wait();
      mem_xor = 32'hC0DE_0000;
      do_reset();
      iInstrReady = 1'b1;
      tick();
      iRedirect   = 1'b1;
      iRedirectPc = 32'h0000_0020;
      tick();
      checks++;
      if (oIbusAddr !== 32'h20) begin
         errors++;
         $display("FAIL redir_wait_setup: got addr %h expected 00000020", oIbusAddr);
      end
      iIbusWait   = 1'b1;
      iRedirectPc = 32'h0000_0200;
      tick();
      iRedirect = 1'b0;
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (oIbusAddr !== 32'h20 || oIbusRead !== 1'b1) begin
            errors++;
            $display("FAIL redir_wait_hold: got addr %h read %b, expected 00000020 1", oIbusAddr, oIbusRead);
         end
         if (i == 0) tick();
      end
      iIbusWait = 1'b0;
      tick();
      checks++;
      if (oIbusAddr !== 32'h200 || oIbusRead !== 1'b1) begin
         errors++;
         $display("FAIL redir_wait_next: got addr %h read %b, expected 00000200 1", oIbusAddr, oIbusRead);
      end
      tick();
      checks++;
      if (oInstrValid !== 1'b0) begin
         errors++;
         $display("FAIL redir_wait_discard: got valid %b expected 0", oInstrValid);
      end
      tick();
      checks++;
      if (oInstrValid !== 1'b1 || oInstrPc !== 32'h200) begin
         errors++;
         $display("FAIL redir_wait_first: got valid %b pc %h, expected 1 00000200", oInstrValid, oInstrPc);
      end
      repeat (3) tick();
   endtask

   task automatic test_back_to_back();
      mem_xor = 32'h7777_0000;
      do_reset();
      iInstrReady = 1'b1;
      tick();
      tick();
      iRedirect   = 1'b1;
      iRedirectPc = 32'h0000_0300;
      tick();
      iRedirectPc = 32'h0000_0400;
      tick();
      iRedirect = 1'b0;
      checks++;
      if (oIbusAddr !== 32'h400) begin
         errors++;
         $display("FAIL b2b_addr: got addr %h expected 00000400", oIbusAddr);
      end
      tick();
      checks++;
      if (oInstrValid !== 1'b0) begin
         errors++;
         $display("FAIL b2b_empty: got valid %b expected 0", oInstrValid);
      end
      tick();
      checks++;
      if (oInstrValid !== 1'b1 || oInstrPc !== 32'h400) begin
         errors++;
         $display("FAIL b2b_first: got valid %b pc %h, expected 1 00000400", oInstrValid, oInstrPc);
      end
      repeat (3) tick();
   endtask

   task automatic test_wrap();
      mem_xor = 32'h0000_AAAA;
      do_reset();
      iInstrReady = 1'b1;
      iRedirect   = 1'b1;
      iRedirectPc = 32'hFFFF_FFFC;
      tick();
      iRedirect = 1'b0;
      checks++;
      if (oIbusAddr !== 32'hFFFF_FFFC) begin
         errors++;
         $display("FAIL wrap_top: got addr %h expected fffffffc", oIbusAddr);
      end
      tick();
      checks++;
      if (oIbusAddr !== 32'h0) begin
         errors++;
         $display("FAIL wrap_zero: got addr %h expected 00000000", oIbusAddr);
      end
      tick();
      checks++;
      if (oInstrValid !== 1'b1 || oInstrPc !== 32'hFFFF_FFFC) begin
         errors++;
         $display("FAIL wrap_first: got valid %b pc %h, expected 1 fffffffc", oInstrValid, oInstrPc);
      end
      repeat (3) tick();
   endtask

   task automatic test_misaligned();
      mem_xor = 32'h3C3C_0000;
      do_reset();
      iInstrReady = 1'b1;
      tick();
      iRedirect   = 1'b1;
      iRedirectPc = 32'h0000_0102;
      tick();
      iRedirect = 1'b0;
`ifdef RISAC_FETCH_FAULT_EN
      checks++;
      if (oFetchFault !== 1'b1 || oIbusRead !== 1'b0 || oInstrPc !== 32'h102 || oInstrValid !== 1'b0) begin
         errors++;
         $display("FAIL fault_set: got fault %b read %b pc %h valid %b, expected 1 0 00000102 0",
                  oFetchFault, oIbusRead, oInstrPc, oInstrValid);
      end
      tick();
      checks++;
      if (oFetchFault !== 1'b1 || oIbusRead !== 1'b0) begin
         errors++;
         $display("FAIL fault_stay: got fault %b read %b, expected 1 0", oFetchFault, oIbusRead);
      end
      iRedirect   = 1'b1;
      iRedirectPc = 32'h0000_0104;
      tick();
      iRedirect = 1'b0;
      checks++;
      if (oFetchFault !== 1'b0 || oIbusRead !== 1'b1 || oIbusAddr !== 32'h104) begin
         errors++;
         $display("FAIL fault_clear: got fault %b read %b addr %h, expected 0 1 00000104",
                  oFetchFault, oIbusRead, oIbusAddr);
      end
      tick();
      tick();
      checks++;
      if (oInstrValid !== 1'b1 || oInstrPc !== 32'h104) begin
         errors++;
         $display("FAIL fault_resume: got valid %b pc %h, expected 1 00000104", oInstrValid, oInstrPc);
      end
`else
      checks++;
      if (oFetchFault !== 1'b0 || oIbusRead !== 1'b1 || oIbusAddr !== 32'h100) begin
         errors++;
         $display("FAIL misalign_force: got fault %b read %b addr %h, expected 0 1 00000100",
                  oFetchFault, oIbusRead, oIbusAddr);
      end
      tick();
      tick();
      checks++;
      if (oInstrValid !== 1'b1 || oInstrPc !== 32'h100) begin
         errors++;
         $display("FAIL misalign_first: got valid %b pc %h, expected 1 00000100", oInstrValid, oInstrPc);
      end
`endif
      repeat (3) tick();
   endtask

   task automatic test_reset_mid();
      mem_xor = 32'h9999_0000;
      do_reset();
      repeat (3) tick();
      rst = 1'b1;
      tick();
      #1;
      checks++;
      if (oIbusRead !== 1'b0 || oLevel !== 3'd0 || oInstrValid !== 1'b0 || oIbusAddr !== 32'h0) begin
         errors++;
         $display("FAIL rstmid_hold: got read %b level %0d valid %b addr %h, expected 0 0 0 0",
                  oIbusRead, oLevel, oInstrValid, oIbusAddr);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (oIbusRead !== 1'b1 || oIbusAddr !== 32'h0) begin
         errors++;
         $display("FAIL rstmid_restart: got read %b addr %h, expected 1 00000000", oIbusRead, oIbusAddr);
      end
      tick();
      checks++;
      if (oLevel !== 3'd0) begin
         errors++;
         $display("FAIL rstmid_drop: got level %0d expected 0", oLevel);
      end
      tick();
      checks++;
      if (oLevel !== 3'd1 || oInstrPc !== 32'h0 || oInstr !== mem_xor) begin
         errors++;
         $display("FAIL rstmid_first: got level %0d pc %h instr %h, expected 1 00000000 %h",
                  oLevel, oInstrPc, oInstr, mem_xor);
      end
      iInstrReady = 1'b1;
      repeat (5) tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_basic();
      test_full();
      test_stall();
      test_redirect_accept();
      test_redirect_wait();
      test_back_to_back();
      test_wrap();
      test_misaligned();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/risac_fetch.md
RISAC_FETCH -- requirements
Module: risac_fetch

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning prefetch FIFO entries (power of 2, 2..16).
REQ-002 SHALL have parameter RESET_PC, default 32'h0, meaning first fetch byte address after reset.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous reset, active-high.
REQ-005 SHALL have port oIbusAddr  output  32  instruction fetch byte address.
REQ-006 SHALL have port oIbusRead  output  1  fetch request.
REQ-007 SHALL have port iIbusWait  input  1  bus not accepting; a request is accepted in a cycle with oIbusRead=1 and iIbusWait=0.
REQ-008 SHALL have port iIbusData  input  32  read data, valid exactly one cycle after acceptance.
REQ-009 SHALL have port oInstr  output  32  FIFO head instruction.
REQ-010 SHALL have port oInstrPc  output  32  byte address of oInstr.
REQ-011 SHALL have port oInstrValid  output  1  FIFO non-empty.
REQ-012 SHALL have port iInstrReady  input  1  consumer pops head when oInstrValid=1.
REQ-013 SHALL have port iRedirect  input  1  flush and restart fetch (branch/jump).
REQ-014 SHALL have port iRedirectPc  input  32  restart byte address.
REQ-015 SHALL have port oLevel  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-016 SHALL have port oFetchFault  output  1  misaligned redirect target (RISAC_FETCH_FAULT_EN only; tied 0 otherwise).

Function
REQ-017 SHALL hold fetch PC fpc; oIbusAddr = fpc; fpc += 4 on each acceptance (mod 2^32 wrap).
REQ-018 SHALL assert oIbusRead only when occupancy + in-flight responses < DEPTH, no fault is pending, and rst=0.
REQ-019 SHALL keep oIbusRead and oIbusAddr stable while iIbusWait=1, until acceptance.
REQ-020 SHALL push {iIbusData, address} into the FIFO in the cycle after acceptance unless that response is marked discard.
REQ-021 SHALL give latency: accept at cycle N -> oInstrValid=1 with that instruction at N+2 (FIFO previously empty).
REQ-022 SHALL present the FIFO head combinationally on oInstr/oInstrPc; pop when oInstrValid & iInstrReady.
REQ-023 SHALL allow push and pop in the same cycle, including at full, with occupancy unchanged.
REQ-024 SHALL never overflow; credit rule REQ-018 guarantees it; pop from empty SHALL be ignored.
REQ-025 On iRedirect=1 SHALL: empty FIFO next cycle; ignore iInstrReady that cycle; mark any response arriving next cycle as discard; fpc <= iRedirectPc.
REQ-026 If a request is stalled (iIbusWait=1) when iRedirect=1, SHALL keep the old address until accepted, discard its response, then issue iRedirectPc.
REQ-027 Back-to-back redirects SHALL each take effect; the last one wins.
REQ-028 FIFO pointers SHALL wrap modulo DEPTH; oLevel SHALL equal pushes minus pops since last flush.

Reset
REQ-029 While rst=1 SHALL drive: oIbusRead=0, oIbusAddr=RESET_PC, oInstrValid=0, oLevel=0, oFetchFault=0, discard flags=0.
REQ-030 Reset mid-operation SHALL drop all FIFO contents and in-flight responses; first cycle after rst falls SHALL issue oIbusRead=1 at RESET_PC.
REQ-031 FIFO data storage SHALL NOT require reset.

Configuration
REQ-032 With macro RISAC_FETCH_FAULT_EN defined: iRedirect with iRedirectPc[1:0]!=0 SHALL flush, set oFetchFault=1 with oInstrPc=iRedirectPc, and stop fetching until the next aligned redirect or reset clears it.
REQ-033 Without RISAC_FETCH_FAULT_EN: iRedirectPc[1:0] SHALL be forced to 2'b00; oFetchFault SHALL be constant 0.

Verification
REQ-034 Reset release, iIbusWait=0, iInstrReady=1, memory word = address -> oIbusAddr 0,4,8,...; oInstr=0 with oInstrPc=0 valid 2 cycles after first accept.
REQ-035 DEPTH=4, iInstrReady=0 -> exactly 4 accepts, oLevel=4, oIbusRead=0; one pop -> exactly one further accept.
REQ-036 iIbusWait=1 for 3 cycles at address 8 -> oIbusAddr held 8, no push; accept on 4th cycle, push at 5th.
REQ-037 iRedirect with iRedirectPc=32'h100 in the same cycle as an accept at 0xC -> 0xC response discarded, oLevel=0, next address 0x100, first valid oInstrPc=0x100.
REQ-038 Redirect during wait at address 0x20 to 0x200 -> 0x20 stays on bus until accepted, its data discarded, then 0x200 issued.
REQ-039 RISAC_FETCH_FAULT_EN defined, redirect to 0x102 -> oFetchFault=1, oIbusRead=0; redirect to 0x104 -> fault clears, fetch resumes at 0x104.
